// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for a 5-stage pipeline. It tracks EX/MEM/WB destinations
// from ID decode and drives the forward selects and the stall/flush/bubble/freeze controls.
module hazard_fwd_ctrl #(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs1_addr,
  input  logic [4:0] i_id_rs2_addr,
  input  logic       i_id_rs1_used,
  input  logic       i_id_rs2_used,
  input  logic [4:0] i_id_rd_addr,
  input  logic       i_id_rd_wren,
  input  logic       i_id_is_load,
  input  logic       i_id_is_md,
  input  logic       i_ex_branch_taken,
  output logic [1:0] o_forward_a,
  output logic [1:0] o_forward_b,
  output logic       o_stall_pc,
  output logic       o_stall_id,
  output logic       o_flush_id,
  output logic       o_bubble_ex,
  output logic       o_stall_ex,
  output logic       o_md_busy
);

  localparam int unsigned CW = $clog2(MD_LATENCY + 1);

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] rd;
    logic       wren;
    logic       load;
    logic       md;
  } ex_t;

  // Nothing downstream of EX needs the load flag, so MEM carries only the destination.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wren;
  } dst_t;

  ex_t          ex_q,  ex_d;
  dst_t         mem_q, mem_d;
  dst_t         wb_q,  wb_d;
  logic [CW-1:0] md_cnt_q, md_cnt_d;

  logic md_busy;
  logic load_use;
  ex_t  id_info;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic used,
                                         input dst_t mem, input dst_t wb);
    if (mem.valid && mem.wren && mem.rd != 5'd0 && mem.rd == rs && used) return 2'b01;
    if (wb.valid  && wb.wren  && wb.rd  != 5'd0 && wb.rd  == rs && used) return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    id_info          = '0;
    id_info.valid    = i_id_valid;
    id_info.rs1      = i_id_rs1_addr;
    id_info.rs2      = i_id_rs2_addr;
    id_info.rs1_used = i_id_rs1_used;
    id_info.rs2_used = i_id_rs2_used;
    id_info.rd       = i_id_rd_addr;
    id_info.wren     = i_id_rd_wren;
    id_info.load     = i_id_is_load;
    id_info.md       = i_id_is_md;
  end

  assign md_busy  = (md_cnt_q != '0) && ex_q.valid && ex_q.md;
  assign load_use = ex_q.valid && ex_q.load && ex_q.wren && (ex_q.rd != 5'd0) && i_id_valid &&
                    ((i_id_rs1_used && i_id_rs1_addr == ex_q.rd) ||
                     (i_id_rs2_used && i_id_rs2_addr == ex_q.rd));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ex_d        = id_info;
    mem_d       = '{valid: ex_q.valid, rd: ex_q.rd, wren: ex_q.wren};
    wb_d        = mem_q;
    md_cnt_d    = (i_id_valid && i_id_is_md) ? CW'(MD_LATENCY - 1) : '0;
    o_forward_a = fwd_sel(ex_q.rs1, ex_q.rs1_used, mem_q, wb_q);
    o_forward_b = fwd_sel(ex_q.rs2, ex_q.rs2_used, mem_q, wb_q);
    o_stall_pc  = 1'b0;
    o_stall_id  = 1'b0;
    o_flush_id  = 1'b0;
    o_bubble_ex = 1'b0;
    o_stall_ex  = 1'b0;
    o_md_busy   = 1'b0;

    if (md_busy) begin
      // EX holds the multi-cycle op while MEM drains to a bubble.
      ex_d       = ex_q;
      mem_d      = '0;
      md_cnt_d   = md_cnt_q - CW'(1);
      o_md_busy  = 1'b1;
      o_stall_ex = 1'b1;
      o_stall_id = 1'b1;
      o_stall_pc = 1'b1;
    end else if (i_ex_branch_taken) begin
      ex_d        = '0;
      md_cnt_d    = '0;
      o_flush_id  = 1'b1;
      o_bubble_ex = 1'b1;
    end else if (load_use) begin
      ex_d        = '0;
      md_cnt_d    = '0;
      o_stall_pc  = 1'b1;
      o_stall_id  = 1'b1;
      o_bubble_ex = 1'b1;
    end

    if (i_reset) begin
      o_forward_a = 2'b00;
      o_forward_b = 2'b00;
      o_stall_pc  = 1'b0;
      o_stall_id  = 1'b0;
      o_flush_id  = 1'b0;
      o_bubble_ex = 1'b0;
      o_stall_ex  = 1'b0;
      o_md_busy   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages update together.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      md_cnt_q <= '0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule
